// File: rtl/piezo_arbiter.sv
// piezo_arbiter: shares one piezo transducer pair between three tune players
// (charge fanfare, battery-low warning, overspeed alarm).
//
// Requests are latched (chrg, batt) or sampled as a level (fast). One player
// is granted at a time by fixed priority fast > batt > chrg. The granted
// player gets a one-cycle go pulse, its drive pair is routed to the pins until
// its done pulse arrives, and then a silent gap is enforced. A watchdog forces
// release if a player never reports done.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_chrg, req_batt         one-cycle request pulses (latched)
//   req_fast                   overspeed alarm level request
//   done_chrg/batt/fast        one-cycle tune-end pulses from the players
//   pz_*/pz_n_*                player drive pairs
//   go_chrg/batt/fast          one-cycle start pulses to the players
//   piezo, piezo_n             transducer drive
//   busy                       high whenever not IDLE
//   grant                      00 none, 01 chrg, 10 batt, 11 fast
//
// Optional build macro PIEZO_PREEMPT_EN: a fast request preempts a playing
// chrg or batt tune, jumping straight to START without a gap.
module piezo_arbiter #(
  parameter int unsigned FAST_SIM    = 1,
  parameter logic [26:0] GAP_CYC     = 27'd2_500_000,
  parameter logic [26:0] TIMEOUT_CYC = 27'h400_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_chrg,
  input  logic       req_batt,
  input  logic       req_fast,
  input  logic       done_chrg,
  input  logic       done_batt,
  input  logic       done_fast,
  input  logic       pz_chrg,
  input  logic       pz_n_chrg,
  input  logic       pz_batt,
  input  logic       pz_n_batt,
  input  logic       pz_fast,
  input  logic       pz_n_fast,
  output logic       go_chrg,
  output logic       go_batt,
  output logic       go_fast,
  output logic       piezo,
  output logic       piezo_n,
  output logic       busy,
  output logic [1:0] grant
);

  typedef enum logic [1:0] {IDLE, START, PLAY, GAP} state_t;

  localparam logic [1:0]  G_NONE = 2'b00;
  localparam logic [1:0]  G_CHRG = 2'b01;
  localparam logic [1:0]  G_BATT = 2'b10;
  localparam logic [1:0]  G_FAST = 2'b11;
  localparam logic [26:0] T_INC  = (FAST_SIM != 0) ? 27'd16 : 27'd1;
  localparam logic [26:0] T_MAX  = '1;

  state_t      state, state_nx;
  logic [1:0]  grant_nx;
  logic [26:0] timer, timer_nx, timer_inc;
  logic        pend_chrg, pend_batt;
  logic        done_sel;
  logic        clr_chrg, clr_batt;

  // Saturating increment: the timer sticks at all-ones rather than wrapping.
  assign timer_inc = (timer > T_MAX - T_INC) ? T_MAX : timer + T_INC;

  always_comb begin
    done_sel = 1'b0;
    case (grant)
      G_CHRG:  done_sel = done_chrg;
      G_BATT:  done_sel = done_batt;
      G_FAST:  done_sel = done_fast;
      default: done_sel = 1'b0;
    endcase
  end

  assign clr_chrg = (state == START) && (grant == G_CHRG);
  assign clr_batt = (state == START) && (grant == G_BATT);

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    timer_nx = timer;
    case (state)
      IDLE: begin
        timer_nx = '0;
        if (req_fast) begin
          grant_nx = G_FAST;
          state_nx = START;
        end else if (pend_batt) begin
          grant_nx = G_BATT;
          state_nx = START;
        end else if (pend_chrg) begin
          grant_nx = G_CHRG;
          state_nx = START;
        end
      end
      START: begin
        timer_nx = '0;
        state_nx = PLAY;
      end
      PLAY: begin
        timer_nx = timer_inc;
        if (done_sel || (timer >= TIMEOUT_CYC)) begin
          timer_nx = '0;
          state_nx = GAP;
        end
`ifdef PIEZO_PREEMPT_EN
        // Preemption overrides a coincident done/timeout: the old tune is
        // abandoned and the alarm starts without a gap.
        if (req_fast && (grant != G_FAST)) begin
          grant_nx = G_FAST;
          timer_nx = '0;
          state_nx = START;
        end
`endif
      end
      GAP: begin
        timer_nx = timer_inc;
        if (timer >= GAP_CYC) begin
          grant_nx = G_NONE;
          timer_nx = '0;
          state_nx = IDLE;
        end
      end
      default: begin
        grant_nx = G_NONE;
        timer_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= G_NONE;
      timer     <= '0;
      pend_chrg <= 1'b0;
      pend_batt <= 1'b0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      timer     <= timer_nx;
      // Set wins over clear so a request landing in its own START replays.
      pend_chrg <= req_chrg | (pend_chrg & ~clr_chrg);
      pend_batt <= req_batt | (pend_batt & ~clr_batt);
    end
  end

  assign go_chrg = (state == START) && (grant == G_CHRG);
  assign go_batt = (state == START) && (grant == G_BATT);
  assign go_fast = (state == START) && (grant == G_FAST);
  assign busy    = (state != IDLE);

  always_comb begin
    piezo   = 1'b0;
    piezo_n = 1'b0;
    if (state == PLAY) begin
      case (grant)
        G_CHRG: begin
          piezo   = pz_chrg;
          piezo_n = pz_n_chrg;
        end
        G_BATT: begin
          piezo   = pz_batt;
          piezo_n = pz_n_batt;
        end
        G_FAST: begin
          piezo   = pz_fast;
          piezo_n = pz_n_fast;
        end
        default: begin
          piezo   = 1'b0;
          piezo_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piezo_arbiter.sv
// tb_piezo_arbiter: directed self-checking bench for piezo_arbiter with
// FAST_SIM=0, GAP_CYC=100, TIMEOUT_CYC=1000. Inputs change 1 ns after the
// rising edge and outputs are sampled there too, away from the edge.
module tb_piezo_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_chrg = 1'b0, req_batt = 1'b0, req_fast = 1'b0;
  logic       done_chrg = 1'b0, done_batt = 1'b0, done_fast = 1'b0;
  logic       pz_chrg = 1'b0, pz_n_chrg = 1'b0;
  logic       pz_batt = 1'b0, pz_n_batt = 1'b0;
  logic       pz_fast = 1'b0, pz_n_fast = 1'b0;
  logic       go_chrg, go_batt, go_fast;
  logic       piezo, piezo_n, busy;
  logic [1:0] grant;
  logic [2:0] go_v;

  int cyc   = 0;
  int n_chk = 0;
  int n_bad = 0;

  assign go_v = {go_fast, go_batt, go_chrg};

  piezo_arbiter #(
    .FAST_SIM    (0),
    .GAP_CYC     (27'd100),
    .TIMEOUT_CYC (27'd1000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_chrg  (req_chrg),
    .req_batt  (req_batt),
    .req_fast  (req_fast),
    .done_chrg (done_chrg),
    .done_batt (done_batt),
    .done_fast (done_fast),
    .pz_chrg   (pz_chrg),
    .pz_n_chrg (pz_n_chrg),
    .pz_batt   (pz_batt),
    .pz_n_batt (pz_n_batt),
    .pz_fast   (pz_fast),
    .pz_n_fast (pz_n_fast),
    .go_chrg   (go_chrg),
    .go_batt   (go_batt),
    .go_fast   (go_fast),
    .piezo     (piezo),
    .piezo_n   (piezo_n),
    .busy      (busy),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle pulse sampled by the next rising edge.
  // sel: 0 req_chrg, 1 req_batt, 2 done_chrg, 3 done_batt, 4 done_fast,
  //      5 req_chrg and req_batt together
  task automatic pulse(input int sel);
    case (sel)
      0: req_chrg = 1'b1;
      1: req_batt = 1'b1;
      2: done_chrg = 1'b1;
      3: done_batt = 1'b1;
      4: done_fast = 1'b1;
      default: begin
        req_chrg = 1'b1;
        req_batt = 1'b1;
      end
    endcase
    tick();
    req_chrg  = 1'b0;
    req_batt  = 1'b0;
    done_chrg = 1'b0;
    done_batt = 1'b0;
    done_fast = 1'b0;
  endtask

  // Wait (bounded) for go bit sel; returns the cycle stamp, -1 on timeout.
  task automatic wait_go(input string tag, input int sel, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (go_v[sel]) begin
        at = cyc;
        break;
      end
    end
    chk({tag, "_seen"}, (at >= 0), 1);
    chk({tag, "_onehot"}, go_v, 32'(3'b001 << sel));
  endtask

  initial begin
    int g0, g1, g2, e;

    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, g1, g2, e;

    // Reset state
    ticks(2);
    chk("reset_outs", {busy, grant, go_v, piezo, piezo_n}, 0);
    rst_n = 1'b1;
    tick();

    // T1: single chrg request, pin tracking, done and gap length
    pz_chrg = 1'b1;
    pz_n_chrg = 1'b0;
    pulse(0);
    chk("t1_still_idle", busy, 0);
    tick();
    chk("t1_go", go_v, 3'b001);
    chk("t1_grant", grant, 2'b01);
    chk("t1_start_silent", {piezo, piezo_n}, 2'b00);
    tick();
    chk("t1_go_one_cycle", go_v, 0);
    chk("t1_busy", busy, 1);
    chk("t1_pins_a", {piezo, piezo_n}, 2'b10);
    pz_chrg = 1'b0;
    pz_n_chrg = 1'b1;
    #1;
    chk("t1_pins_b", {piezo, piezo_n}, 2'b01);
    ticks(298);
    pulse(2);
    chk("t1_gap_silent", {piezo, piezo_n, busy}, 3'b001);
    ticks(100);
    chk("t1_gap_busy", busy, 1);
    tick();
    chk("t1_idle", {busy, grant}, 0);

    // T2: simultaneous chrg+batt, batt first, chrg 102 edges after done_batt
    pulse(5);
    tick();
    chk("t2_go_batt", go_v, 3'b010);
    chk("t2_grant_batt", grant, 2'b10);
    ticks(50);
    pulse(3);
    e = cyc;
    wait_go("t2_go_chrg", 0, 200, g0);
    chk("t2_chrg_delay", g0 - e, 102);
    chk("t2_grant_chrg", grant, 2'b01);
    tick();
    pulse(2);
    ticks(101);
    chk("t2_idle", {busy, grant}, 0);

    // T3: held overspeed alarm repeats every 1+199+101+1 = 302 cycles when
    // done arrives 200 edges after go
    req_fast = 1'b1;
    wait_go("t3_go0", 2, 10, g0);
    chk("t3_grant", grant, 2'b11);
    ticks(199);
    pulse(4);
    wait_go("t3_go1", 2, 400, g1);
    chk("t3_spacing1", g1 - g0, 302);
    ticks(199);
    pulse(4);
    wait_go("t3_go2", 2, 400, g2);
    chk("t3_spacing2", g2 - g1, 302);
    req_fast = 1'b0;
    ticks(199);
    pulse(4);
    ticks(100);
    chk("t3_final_gap", busy, 1);
    tick();
    chk("t3_idle", {busy, grant}, 0);
    ticks(5);
    chk("t3_no_regrant", busy, 0);

    // T4: watchdog release at timer==1000, then gap, then stray done ignored
    pz_chrg = 1'b1;
    pz_n_chrg = 1'b0;
    pulse(0);
    wait_go("t4_go", 0, 5, g0);
    ticks(1001);
    chk("t4_last_play", {piezo, piezo_n, busy}, 3'b101);
    tick();
    chk("t4_forced_gap", {piezo, piezo_n, busy}, 3'b001);
    ticks(100);
    chk("t4_gap_busy", busy, 1);
    tick();
    chk("t4_idle", {busy, grant}, 0);
    pulse(2);
    ticks(3);
    chk("t4_stray_done", {busy, grant}, 0);

    // T5: asynchronous reset mid-PLAY drops grant, silences pins, clears pends
    pulse(0);
    wait_go("t5_go", 0, 5, g0);
    ticks(20);
    pulse(1);
    ticks(5);
    chk("t5_playing", {piezo, busy, grant}, 4'b1101);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_reset", {busy, grant, piezo, piezo_n}, 0);
    tick();
    rst_n = 1'b1;
    ticks(5);
    chk("t5_pend_cleared", {busy, grant}, 0);

`ifdef PIEZO_PREEMPT_EN
    // T6: fast preempts a chrg tune; chrg is not replayed
    pz_fast = 1'b0;
    pz_n_fast = 1'b1;
    pulse(0);
    wait_go("t6_go_chrg", 0, 5, g0);
    ticks(50);
    chk("t6_chrg_pins", {piezo, piezo_n}, 2'b10);
    req_fast = 1'b1;
    tick();
    chk("t6_go_fast", go_v, 3'b100);
    chk("t6_grant_fast", grant, 2'b11);
    req_fast = 1'b0;
    tick();
    chk("t6_fast_pins", {piezo, piezo_n}, 2'b01);
    ticks(10);
    pulse(2);
    chk("t6_old_done_ignored", {busy, grant, piezo_n}, 4'b1111);
    ticks(10);
    pulse(4);
    ticks(101);
    chk("t6_idle", {busy, grant}, 0);
    ticks(5);
    chk("t6_no_replay", {busy, grant}, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
